onchip_memory_dp: RTL and testbench
===================================

Name: onchip_memory_dp

Overview:
- Parametrised dual-port successor to the single-port on-chip RAM. Two independent Avalon-MM slave ports (s1, s2) share one inferred byte-enabled RAM.
- Adds an explicit read strobe, readdatavalid, and selectable read latency of 1 or 2.
- Defines collision handling, out-of-range detection and a sticky error flag.
- Sits on the Nios II data/instruction fabric as tightly-coupled program/data memory.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 13, word-address width.
- DEPTH, 6500, number of words implemented; must be ≤ 2**ADDR_W.
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values 1 or 2.
- INIT_FILE, "onchip_memory_dp.hex", hex image loaded at elaboration; empty string means no init.

Ports:
- clk  in  1  single clock for both ports.
- reset  in  1  synchronous, active-high.
- sN_address  in  ADDR_W  word address (N = 1, 2; every sN_ port exists per port).
- sN_byteenable  in  DATA_W/8  write byte lanes.
- sN_chipselect  in  1  port select.
- sN_read  in  1  read request.
- sN_write  in  1  write request.
- sN_writedata  in  DATA_W  write data.
- sN_clken  in  1  port clock enable; low stalls the port.
- sN_readdata  out  DATA_W  read data.
- sN_readdatavalid  out  1  one-cycle pulse per accepted read.
- oob_err  out  1  sticky flag: an access was accepted with address ≥ DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset effect: sN_readdata=0, sN_readdatavalid=0, oob_err=0, read pipelines flushed. RAM contents are not cleared.
- Accept: a port accepts an access in a cycle where sN_chipselect & sN_clken & (sN_read | sN_write). There is no waitrequest; every access is accepted the cycle it is presented.
- Read and write both high on one port: the write is performed and the read is ignored (no readdatavalid).
- Write: on the accept edge, only lanes with byteenable=1 are updated.
- Read latency 1: readdata and readdatavalid are registered and appear the cycle after accept.
- Read latency 2: one extra output register stage.
- readdatavalid pulses for exactly one cycle per accepted read. readdata holds its last value otherwise.
- Clock enable: sN_clken=0 freezes that port's pipeline stages, including readdatavalid. A pending result is delivered after clken returns high, with relative cycle count preserved.
- Same-port read-during-write: not possible (see the read-and-write rule above).
- Mixed-port read during write, same address, same cycle: the reader gets OLD data. Any write-forwarding is forbidden.
- Write/write collision, same address, same cycle:
  - s1 wins on lanes where both byteenables are 1.
  - Lanes enabled by only one port take that port's data.
- Out-of-range (address ≥ DEPTH):
  - Write is dropped, RAM unchanged.
  - Read returns all-zero data with a normal readdatavalid pulse.
  - oob_err sets on the accept edge and stays set until reset.
- Reset mid-operation: in-flight reads are discarded; no readdatavalid is issued for them. An access presented in the reset cycle is not accepted.
- Widths: byteenable width is DATA_W/8. Address comparison against DEPTH is unsigned at ADDR_W bits.

Decomposition:
- Shared package onchip_mem_pkg holds:
  - constants LAT_MIN=1, LAT_MAX=2;
  - function be_w(DATA_W) returning DATA_W/8;
  - elaboration check macro: DATA_W%8==0, DEPTH ≤ 2**ADDR_W, READ_LATENCY in {1,2}.
- One sub-module, onchip_mem_rd_pipe, instantiated once per port:
  - clken-gated valid/data pipeline of depth READ_LATENCY;
  - synchronous reset;
  - out-of-range zero substitution.
- RAM array, collision resolution and oob_err live in the top level.

Test Plan:
- Basic per-port write/read, latency 1: s1 writes 0xDEADBEEF to addr 5 with be=4'hF, then reads addr 5 → s1_readdata=0xDEADBEEF and readdatavalid high exactly 1 cycle after the read accept. s2 reads addr 5 → same value.
- Byte enables and collision: addr 7 preset to 0x00000000. In the same cycle, s1 writes 0x11223344 be=4'b0011 and s2 writes 0xAABBCCDD be=4'b0110. Readback = 0x00BB3344.
- Mixed-port read-during-write: addr 9 = 0x12345678. s1 writes 0xCAFEF00D to addr 9 while s2 reads addr 9 in the same cycle → s2 gets 0x12345678; the next s2 read gets 0xCAFEF00D.
- Latency 2 with clken stall: READ_LATENCY=2. s1 reads addr 3 (=0x55), then s1_clken=0 for 3 cycles immediately after accept → readdatavalid occurs 5 cycles after accept, single pulse, data 0x55.
- Out-of-range: DEPTH=6500. s2 writes 0xFFFFFFFF to addr 6500 → oob_err=1 next cycle. Reading addr 6500 returns 0 with valid. Addr 6499 is unchanged. oob_err stays 1 until reset.
- Reset mid-read: READ_LATENCY=2. s1 reads addr 1, reset is asserted the following cycle → no readdatavalid, readdata=0. RAM content at addr 1 is intact on a post-reset read.

Source files
------------

// File: rtl/onchip_mem_pkg.sv
// Shared constants and helpers for the dual-port on-chip RAM.
package onchip_mem_pkg;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 2;

   // Number of byte lanes in a data word.
   function automatic int be_w(input int data_w);
      return data_w / 8;
   endfunction

   // Legal parameter set: whole bytes, depth fits the address space, supported latency.
   function automatic bit cfg_ok(input int data_w, input int addr_w, input int depth,
                                 input int lat);
      return (data_w > 0) && (data_w % 8 == 0) && (depth > 0) &&
             (longint'(depth) <= (longint'(1) << addr_w)) &&
             (lat >= LAT_MIN) && (lat <= LAT_MAX);
   endfunction

endpackage

// File: rtl/onchip_mem_rd_pipe.sv
// Per-port read return path: clock-enable gated valid/data pipeline of depth
// READ_LATENCY, with zero substitution for out-of-range reads.
module onchip_mem_rd_pipe
   import onchip_mem_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              i_reset,
   input  logic              i_clken,
   input  logic              i_rd_acc,
   input  logic              i_oob,
   input  logic [DATA_W-1:0] i_rd_word,
   output logic [DATA_W-1:0] o_readdata,
   output logic              o_readdatavalid
);

   logic              r_vld_p1;
   logic [DATA_W-1:0] r_dat_p1;
   logic              w_vld_out;
   logic [DATA_W-1:0] w_dat_out;

   // Stage 1: capture the RAM word on the accept edge; frozen while clken is low.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         r_vld_p1 <= 1'b0;
         r_dat_p1 <= '0;
      end else if (i_clken) begin
         r_vld_p1 <= i_rd_acc;
         if (i_rd_acc) r_dat_p1 <= i_oob ? '0 : i_rd_word;
      end
   end

   if (READ_LATENCY >= LAT_MAX) begin : g_lat2
      logic              r_vld_p2;
      logic [DATA_W-1:0] r_dat_p2;

      // Stage 2: extra output register, advancing only on enabled cycles.
      always_ff @(posedge clk) begin
         if (i_reset) begin
            r_vld_p2 <= 1'b0;
            r_dat_p2 <= '0;
         end else if (i_clken) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) r_dat_p2 <= r_dat_p1;
         end
      end

      assign w_vld_out = r_vld_p2;
      assign w_dat_out = r_dat_p2;
   end else begin : g_lat1
      assign w_vld_out = r_vld_p1;
      assign w_dat_out = r_dat_p1;
   end

   // A stalled port sees no valid; the held result shows on the next enabled
   // cycle, so each read produces exactly one visible pulse.
   assign o_readdatavalid = w_vld_out & i_clken;
   assign o_readdata      = w_dat_out;

endmodule

// File: rtl/onchip_memory_dp.sv
// Dual-port byte-enabled on-chip RAM with two Avalon-MM slave ports sharing
// one array, s1 priority on same-address lane collisions, and a sticky
// out-of-range flag.
module onchip_memory_dp
   import onchip_mem_pkg::*;
#(
   parameter int    DATA_W       = 32,
   parameter int    ADDR_W       = 13,
   parameter int    DEPTH        = 6500,
   parameter int    READ_LATENCY = 1,
   parameter string INIT_FILE    = "onchip_memory_dp.hex"
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_W-1:0]         s1_address,
   input  logic [be_w(DATA_W)-1:0]   s1_byteenable,
   input  logic                      s1_chipselect,
   input  logic                      s1_read,
   input  logic                      s1_write,
   input  logic [DATA_W-1:0]         s1_writedata,
   input  logic                      s1_clken,
   output logic [DATA_W-1:0]         s1_readdata,
   output logic                      s1_readdatavalid,
   input  logic [ADDR_W-1:0]         s2_address,
   input  logic [be_w(DATA_W)-1:0]   s2_byteenable,
   input  logic                      s2_chipselect,
   input  logic                      s2_read,
   input  logic                      s2_write,
   input  logic [DATA_W-1:0]         s2_writedata,
   input  logic                      s2_clken,
   output logic [DATA_W-1:0]         s2_readdata,
   output logic                      s2_readdatavalid,
   output logic                      oob_err
);

   localparam int          BE_W    = be_w(DATA_W);
   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   if (!cfg_ok(DATA_W, ADDR_W, DEPTH, READ_LATENCY)) begin : g_cfg_err
      $error("onchip_memory_dp: illegal DATA_W/ADDR_W/DEPTH/READ_LATENCY combination");
   end

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              r_oob_err;

   logic              w_acc1, w_acc2, w_rd1, w_rd2, w_wr1, w_wr2, w_oob1, w_oob2, w_same;
   logic [DATA_W-1:0] w_q1, w_q2, w_new1, w_new2;

   // Nothing is accepted in a reset cycle; write has priority over read on one port.
   assign w_acc1 = s1_chipselect & s1_clken & (s1_read | s1_write) & ~reset;
   assign w_acc2 = s2_chipselect & s2_clken & (s2_read | s2_write) & ~reset;
   assign w_wr1  = w_acc1 & s1_write;
   assign w_wr2  = w_acc2 & s2_write;
   assign w_rd1  = w_acc1 & ~s1_write;
   assign w_rd2  = w_acc2 & ~s2_write;
   assign w_oob1 = (32'(s1_address) >= DEPTH_U);
   assign w_oob2 = (32'(s2_address) >= DEPTH_U);
   assign w_same = (s1_address == s2_address);

   // Pre-edge word at each address: this is what a reader gets even when the
   // other port writes the same word on the same edge (no forwarding).
   assign w_q1 = r_mem[s1_address];
   assign w_q2 = r_mem[s2_address];

   // Merge byte lanes into the stored word. On a shared address the s1 word
   // also carries s2's lanes that s1 leaves alone, so writing s1 last keeps both.
   always_comb begin
      w_new1 = w_q1;
      w_new2 = w_q2;
      for (int b = 0; b < BE_W; b++) begin
         if (s2_byteenable[b]) w_new2[b*8 +: 8] = s2_writedata[b*8 +: 8];
         if (s1_byteenable[b])
            w_new1[b*8 +: 8] = s1_writedata[b*8 +: 8];
         else if (w_same && w_wr2 && s2_byteenable[b])
            w_new1[b*8 +: 8] = s2_writedata[b*8 +: 8];
      end
   end

   // RAM write; out-of-range writes are dropped, s1 lands last on collisions.
   always_ff @(posedge clk) begin
      if (w_wr2 && !w_oob2) r_mem[s2_address] <= w_new2;
      if (w_wr1 && !w_oob1) r_mem[s1_address] <= w_new1;
   end

   // Sticky out-of-range flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset)
         r_oob_err <= 1'b0;
      else if ((w_acc1 && w_oob1) || (w_acc2 && w_oob2))
         r_oob_err <= 1'b1;
   end

   assign oob_err = r_oob_err;

   onchip_mem_rd_pipe #(.DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)) u_rd_pipe_s1 (
      .clk             (clk),
      .i_reset         (reset),
      .i_clken         (s1_clken),
      .i_rd_acc        (w_rd1),
      .i_oob           (w_oob1),
      .i_rd_word       (w_q1),
      .o_readdata      (s1_readdata),
      .o_readdatavalid (s1_readdatavalid)
   );

   onchip_mem_rd_pipe #(.DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)) u_rd_pipe_s2 (
      .clk             (clk),
      .i_reset         (reset),
      .i_clken         (s2_clken),
      .i_rd_acc        (w_rd2),
      .i_oob           (w_oob2),
      .i_rd_word       (w_q2),
      .o_readdata      (s2_readdata),
      .o_readdatavalid (s2_readdatavalid)
   );

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Bench for onchip_memory_dp: a latency-1 and a latency-2 instance share the
// same stimulus; a behavioural model predicts every output each cycle.
module tb_onchip_memory_dp;

   localparam int DW    = 32;
   localparam int AW    = 13;
   localparam int DEPTH = 6500;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset;
   logic [1:0][AW-1:0]  a;
   logic [1:0][3:0]     be;
   logic [1:0]          cs, rd, wr, ce;
   logic [1:0][DW-1:0]  wd;

   logic [DW-1:0] l1_rd1, l1_rd2, l2_rd1, l2_rd2;
   logic          l1_rv1, l1_rv2, l2_rv1, l2_rv2, l1_oob, l2_oob;

   onchip_memory_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(1),
                      .INIT_FILE("")) u_dut_l1 (
      .clk(clk), .reset(reset),
      .s1_address(a[0]), .s1_byteenable(be[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]),
      .s1_write(wr[0]), .s1_writedata(wd[0]), .s1_clken(ce[0]),
      .s1_readdata(l1_rd1), .s1_readdatavalid(l1_rv1),
      .s2_address(a[1]), .s2_byteenable(be[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]),
      .s2_write(wr[1]), .s2_writedata(wd[1]), .s2_clken(ce[1]),
      .s2_readdata(l1_rd2), .s2_readdatavalid(l1_rv2),
      .oob_err(l1_oob)
   );

   onchip_memory_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(2),
                      .INIT_FILE("")) u_dut_l2 (
      .clk(clk), .reset(reset),
      .s1_address(a[0]), .s1_byteenable(be[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]),
      .s1_write(wr[0]), .s1_writedata(wd[0]), .s1_clken(ce[0]),
      .s1_readdata(l2_rd1), .s1_readdatavalid(l2_rv1),
      .s2_address(a[1]), .s2_byteenable(be[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]),
      .s2_write(wr[1]), .s2_writedata(wd[1]), .s2_clken(ce[1]),
      .s2_readdata(l2_rd2), .s2_readdatavalid(l2_rv2),
      .oob_err(l2_oob)
   );

   // Reference model: word memory, per-port count of enabled cycles, and per
   // (instance, port) queues of pending reads keyed by the enabled-cycle count
   // at which each must appear. Stream index k = instance*2 + port.
   logic [DW-1:0] m_mem [DEPTH];
   int            en_cnt [2];
   int            tq [4][$];
   logic [DW-1:0] dq [4][$];
   logic [DW-1:0] last [4];
   logic          exp_oob;
   int            n_total = 0;
   int            n_bad   = 0;
   bit            chk_en  = 1'b0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] get_rd(input int k);
      case (k)
         0:       return l1_rd1;
         1:       return l1_rd2;
         2:       return l2_rd1;
         default: return l2_rd2;
      endcase
   endfunction

   function automatic logic get_rv(input int k);
      case (k)
         0:       return l1_rv1;
         1:       return l1_rv2;
         2:       return l2_rv1;
         default: return l2_rv2;
      endcase
   endfunction

   // Compare outputs of the current cycle against the model.
   task automatic sample();
      for (int p = 0; p < 2; p++) if (ce[p]) en_cnt[p]++;
      for (int k = 0; k < 4; k++) begin
         int            p;
         logic          ev;
         logic [DW-1:0] ed;
         p  = k % 2;
         ev = 1'b0;
         ed = last[k];
         if (tq[k].size() > 0 && tq[k][0] == en_cnt[p]) begin
            ev      = 1'b1;
            ed      = dq[k][0];
            last[k] = ed;
            void'(tq[k].pop_front());
            void'(dq[k].pop_front());
         end
         if (chk_en) begin
            chk($sformatf("valid%0d", k), {31'b0, get_rv(k)}, {31'b0, ev});
            if (ev || ce[p]) chk($sformatf("data%0d", k), get_rd(k), ed);
         end
      end
      if (chk_en) begin
         chk("oob_l1", {31'b0, l1_oob}, {31'b0, exp_oob});
         chk("oob_l2", {31'b0, l2_oob}, {31'b0, exp_oob});
      end
   endtask

   // Apply this cycle's inputs to the model as the clock edge would.
   task automatic model_update();
      logic [1:0] acc, oobp;
      if (reset) begin
         for (int k = 0; k < 4; k++) begin
            tq[k].delete();
            dq[k].delete();
            last[k] = '0;
         end
         exp_oob = 1'b0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            acc[p]  = cs[p] & ce[p] & (rd[p] | wr[p]);
            oobp[p] = (int'(a[p]) >= DEPTH);
            if (acc[p] && oobp[p]) exp_oob = 1'b1;
         end
         for (int p = 0; p < 2; p++) begin
            if (acc[p] && !wr[p]) begin
               for (int d = 0; d < 2; d++) begin
                  tq[d*2+p].push_back(en_cnt[p] + d + 1);
                  dq[d*2+p].push_back(oobp[p] ? '0 : m_mem[a[p]]);
               end
            end
         end
         for (int p = 1; p >= 0; p--) begin
            if (acc[p] && wr[p] && !oobp[p])
               for (int b = 0; b < 4; b++)
                  if (be[p][b]) m_mem[a[p]][b*8 +: 8] = wd[p][b*8 +: 8];
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      sample();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0;
      cs = '0; rd = '0; wr = '0; ce = 2'b11; be = '0; wd = '0; a = '0;
   endtask

   task automatic access(input int p, input bit w, input int addr, input logic [DW-1:0] d,
                         input logic [3:0] bev);
      cs[p] = 1'b1;
      rd[p] = ~w;
      wr[p] = w;
      a[p]  = AW'(addr);
      wd[p] = d;
      be[p] = bev;
   endtask

   task automatic settle(input int n);
      idle();
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic [AW-1:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)      return AW'($urandom_range(0, 15));
      else if (r < 9) return AW'(6496 + $urandom_range(0, 3));
      else begin
         case ($urandom_range(0, 2))
            0:       return AW'(6500);
            1:       return AW'(6501);
            default: return AW'(8191);
         endcase
      end
   endfunction

   initial begin
      en_cnt[0] = 0;
      en_cnt[1] = 0;
      exp_oob   = 1'b0;
      for (int k = 0; k < 4; k++) last[k] = '0;

      // Reset
      idle();
      reset = 1'b1;
      step();
      chk_en = 1'b1;
      step();
      idle();
      chk("rst_rd_l1", l1_rd1, '0);
      chk("rst_rd_l2", l2_rd2, '0);
      chk("rst_oob", {31'b0, l2_oob}, '0);

      // Preload every address the bench reads
      for (int i = 0; i < 16; i++) begin
         idle();
         access(0, 1'b1, i, '0, 4'hF);
         access(1, 1'b1, 6496 + (i % 4), 32'h6490_0000 + (i % 4), 4'hF);
         step();
      end
      idle();
      access(0, 1'b1, 3, 32'h55, 4'hF);
      access(1, 1'b1, 9, 32'h1234_5678, 4'hF);
      step();
      idle();
      access(0, 1'b1, 1, 32'hA5A5_0001, 4'hF);
      step();

      // Basic write then read on both ports
      idle(); access(0, 1'b1, 5, 32'hDEAD_BEEF, 4'hF); step();
      idle(); access(0, 1'b0, 5, '0, 4'h0); step();
      idle(); access(1, 1'b0, 5, '0, 4'h0); step();
      settle(3);
      chk("basic_s1_l1", l1_rd1, 32'hDEAD_BEEF);
      chk("basic_s1_l2", l2_rd1, 32'hDEAD_BEEF);
      chk("basic_s2_l1", l1_rd2, 32'hDEAD_BEEF);

      // Same-cycle write/write collision with partial byte enables
      idle();
      access(0, 1'b1, 7, 32'h1122_3344, 4'b0011);
      access(1, 1'b1, 7, 32'hAABB_CCDD, 4'b0110);
      step();
      idle(); access(0, 1'b0, 7, '0, 4'h0); step();
      settle(3);
      chk("collide_l1", l1_rd1, 32'h00BB_3344);
      chk("collide_l2", l2_rd1, 32'h00BB_3344);

      // Mixed-port read during write returns old data
      idle();
      access(0, 1'b1, 9, 32'hCAFE_F00D, 4'hF);
      access(1, 1'b0, 9, '0, 4'h0);
      step();
      settle(3);
      chk("rdw_old_l1", l1_rd2, 32'h1234_5678);
      chk("rdw_old_l2", l2_rd2, 32'h1234_5678);
      idle(); access(1, 1'b0, 9, '0, 4'h0); step();
      settle(3);
      chk("rdw_new_l2", l2_rd2, 32'hCAFE_F00D);

      // Clock-enable stall right after a read accept
      idle(); access(0, 1'b0, 3, '0, 4'h0); step();
      idle(); ce[0] = 1'b0;
      for (int i = 0; i < 3; i++) step();
      settle(3);
      chk("stall_l2", l2_rd1, 32'h55);
      chk("stall_l1", l1_rd1, 32'h55);

      // Out-of-range write and read
      idle(); access(1, 1'b1, 6500, 32'hFFFF_FFFF, 4'hF); step();
      idle();
      chk("oob_set_l1", {31'b0, l1_oob}, 32'd1);
      chk("oob_set_l2", {31'b0, l2_oob}, 32'd1);
      access(1, 1'b0, 6500, '0, 4'h0); step();
      settle(3);
      chk("oob_rd_l2", l2_rd2, '0);
      idle(); access(1, 1'b0, 6499, '0, 4'h0); step();
      settle(4);
      chk("edge_rd_l2", l2_rd2, 32'h6490_0003);
      chk("oob_sticky", {31'b0, l2_oob}, 32'd1);

      // Reset while a read is in flight
      idle(); access(0, 1'b0, 1, '0, 4'h0); step();
      idle(); reset = 1'b1; step();
      settle(3);
      chk("rst_mid_l2", l2_rd1, '0);
      chk("rst_mid_l1", l1_rd1, '0);
      chk("rst_oob_clr", {31'b0, l1_oob}, '0);
      idle(); access(0, 1'b0, 1, '0, 4'h0); step();
      settle(3);
      chk("rst_keep_l2", l2_rd1, 32'hA5A5_0001);

      // Randomized traffic on both ports
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         for (int p = 0; p < 2; p++) begin
            cs[p] = ($urandom_range(0, 9) < 8);
            rd[p] = 1'($urandom_range(0, 1));
            wr[p] = ($urandom_range(0, 2) == 0);
            ce[p] = ($urandom_range(0, 9) < 8);
            be[p] = 4'($urandom);
            wd[p] = $urandom;
            a[p]  = pick_addr();
         end
         step();
      end
      settle(4);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
